// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver/host and the receive FIFO.
// The master side drives received bytes and read requests; the slave side is the FIFO.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic          rx_done;
  logic [7:0]    rx_data_in;
  logic          rx_error;
  logic          rd_en;
  logic          clear_overflow;
  logic [7:0]    data_out;
  logic          data_err;
  logic          data_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;

  modport master (
    output rx_done, rx_data_in, rx_error, rd_en, clear_overflow,
    input  data_out, data_err, data_valid, empty, full, count, overflow
  );

  modport slave (
    input  rx_done, rx_data_in, rx_error, rd_en, clear_overflow,
    output data_out, data_err, data_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side circular FIFO: one write per RxDone rising edge, registered 1-cycle read.
// Optional macro UART_RXFIFO_DROP_ERR_EN discards errored bytes and ties DataErr to 0.
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int CW = ADDR_WIDTH + 1;
`ifdef UART_RXFIFO_DROP_ERR_EN
  localparam int MEM_W = 8;
`else
  localparam int MEM_W = 9;
`endif

  logic [MEM_W-1:0]      mem [DEPTH];
  logic [MEM_W-1:0]      wr_word_s;
  logic [MEM_W-1:0]      rd_word_s;

  logic                  rx_done_q, rx_done_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [7:0]            data_q, data_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;

  logic                  wr_ev_s, wr_ok_s, wr_acc_s, rd_ev_s;

  // Next-state logic for pointers, occupancy, read data and overflow.
  always_comb begin
    rx_done_d = bus.rx_done;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    data_d    = data_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    rd_word_s = mem[rd_ptr_q];

    wr_ev_s = bus.rx_done && !rx_done_q;
`ifdef UART_RXFIFO_DROP_ERR_EN
    wr_ok_s   = wr_ev_s && !bus.rx_error;
    wr_word_s = bus.rx_data_in;
`else
    wr_ok_s   = wr_ev_s;
    wr_word_s = {bus.rx_error, bus.rx_data_in};
`endif
    rd_ev_s  = bus.rd_en && (count_q != {CW{1'b0}});
    // A simultaneous read frees a slot, so a full FIFO still accepts the write.
    wr_acc_s = wr_ok_s && ((count_q != CW'(DEPTH)) || rd_ev_s);

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_ev_s) begin
      rd_ptr_d = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      data_d   = rd_word_s[7:0];
`ifdef UART_RXFIFO_DROP_ERR_EN
      err_d    = 1'b0;
`else
      err_d    = rd_word_s[8];
`endif
      valid_d  = 1'b1;
    end else begin
      valid_d  = 1'b0;
    end

    count_d = count_q + {{(CW-1){1'b0}}, wr_acc_s} - {{(CW-1){1'b0}}, rd_ev_s};
    empty_d = (count_d == {CW{1'b0}});
    full_d  = (count_d == CW'(DEPTH));

    if (wr_ok_s && !wr_acc_s) begin
      ovf_d = 1'b1;
    end else if (bus.clear_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_done_q <= 1'b0;
      wr_ptr_q  <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q  <= {ADDR_WIDTH{1'b0}};
      count_q   <= {CW{1'b0}};
      data_q    <= 8'h00;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rx_done_q <= rx_done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !rst) begin
      mem[wr_ptr_q] <= wr_word_s;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_err   = err_q;
  assign bus.data_valid = valid_q;
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;
  assign bus.count      = count_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stored bytes are queued at write time and
// a negedge monitor pops and compares each DataValid pulse.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [8:0] exp_q [$];
  logic [8:0] e;
  logic [7:0] b;

  uart_rx_fifo_if #(.AW(4)) bus ();
  uart_rx_fifo #(.DEPTH(16), .ADDR_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic err);
    bus.rx_data_in = d;
    bus.rx_error   = err;
    bus.rx_done    = 1'b1;
    tick();
    bus.rx_done    = 1'b0;
    tick();
  endtask

  task automatic rd1();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    tick();
  endtask

  // Monitor: every DataValid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_valid: got data %0h with no expected entry at %0t", bus.data_out, $time);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", {24'd0, bus.data_out}, {24'd0, e[7:0]});
        check("rd_err", {31'd0, bus.data_err}, {31'd0, e[8]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.rx_done = 1'b0; bus.rx_data_in = 8'h00; bus.rx_error = 1'b0;
    bus.rd_en = 1'b0; bus.clear_overflow = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_count", {27'd0, bus.count}, 32'd0);
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    check("rst_valid", {31'd0, bus.data_valid}, 32'd0);
    check("rst_dout", {24'd0, bus.data_out}, 32'd0);

    // Single byte round trip
    exp_q.push_back({1'b0, 8'hA5});
    wr(8'hA5, 1'b0);
    check("t1_count", {27'd0, bus.count}, 32'd1);
    check("t1_empty", {31'd0, bus.empty}, 32'd0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("t1_valid", {31'd0, bus.data_valid}, 32'd1);
    check("t1_empty_after", {31'd0, bus.empty}, 32'd1);
    tick();

    // Write and read together while empty: no fall-through
    bus.rx_data_in = 8'h42; bus.rx_error = 1'b0;
    exp_q.push_back({1'b0, 8'h42});
    bus.rx_done = 1'b1; bus.rd_en = 1'b1;
    tick();
    bus.rx_done = 1'b0; bus.rd_en = 1'b0;
    check("empty_rw_valid", {31'd0, bus.data_valid}, 32'd0);
    check("empty_rw_count", {27'd0, bus.count}, 32'd1);
    tick();
    rd1();

    // RxDone held high for 20 cycles writes once
    exp_q.push_back({1'b0, 8'h3C});
    bus.rx_data_in = 8'h3C;
    bus.rx_done = 1'b1;
    repeat (20) tick();
    bus.rx_done = 1'b0;
    tick();
    check("t2_count", {27'd0, bus.count}, 32'd1);
    rd1();
    check("t2_drained", {27'd0, bus.count}, 32'd0);

    // Fill past capacity
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back({1'b0, 8'(i)});
      wr(8'(i), 1'b0);
      if (i == 15) begin
        check("t3_full16", {31'd0, bus.full}, 32'd1);
        check("t3_ovf16", {31'd0, bus.overflow}, 32'd0);
      end
    end
    check("t3_ovf17", {31'd0, bus.overflow}, 32'd1);
    check("t3_count17", {27'd0, bus.count}, 32'd16);
    bus.rd_en = 1'b1;
    repeat (16) tick();
    bus.rd_en = 1'b0;
    tick();
    check("t3_empty", {31'd0, bus.empty}, 32'd1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("empty_rd_valid", {31'd0, bus.data_valid}, 32'd0);
    check("empty_rd_hold", {24'd0, bus.data_out}, 32'h0F);
    tick();
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;
    check("t3_clear", {31'd0, bus.overflow}, 32'd0);

    // Full FIFO: simultaneous write and read
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({1'b0, 8'h20 + 8'(i)});
      wr(8'h20 + 8'(i), 1'b0);
    end
    exp_q.push_back({1'b0, 8'h99});
    bus.rx_data_in = 8'h99;
    bus.rx_done = 1'b1; bus.rd_en = 1'b1;
    tick();
    bus.rx_done = 1'b0; bus.rd_en = 1'b0;
    check("t4_count", {27'd0, bus.count}, 32'd16);
    check("t4_ovf", {31'd0, bus.overflow}, 32'd0);
    check("t4_valid", {31'd0, bus.data_valid}, 32'd1);
    tick();
    // Dropped write and clear in the same cycle: set wins
    bus.rx_data_in = 8'h77;
    bus.rx_done = 1'b1; bus.clear_overflow = 1'b1;
    tick();
    bus.rx_done = 1'b0; bus.clear_overflow = 1'b0;
    check("set_wins_ovf", {31'd0, bus.overflow}, 32'd1);
    check("set_wins_count", {27'd0, bus.count}, 32'd16);
    tick();
    bus.rd_en = 1'b1;
    repeat (16) tick();
    bus.rd_en = 1'b0;
    tick();
    check("t4_empty", {31'd0, bus.empty}, 32'd1);
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;

    // Pointer wrap with write/read pairs
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back({1'b0, b});
      wr(b, 1'b0);
      check("t5_count_w", {27'd0, bus.count}, 32'd1);
      rd1();
      check("t5_count_r", {27'd0, bus.count}, 32'd0);
    end

    // Errored byte
`ifdef UART_RXFIFO_DROP_ERR_EN
    wr(8'h5A, 1'b1);
    check("t6_count", {27'd0, bus.count}, 32'd0);
    check("t6_ovf", {31'd0, bus.overflow}, 32'd0);
    check("t6_empty", {31'd0, bus.empty}, 32'd1);
`else
    exp_q.push_back({1'b1, 8'h5A});
    wr(8'h5A, 1'b1);
    check("t6_count", {27'd0, bus.count}, 32'd1);
    rd1();
    check("t6_err", {31'd0, bus.data_err}, 32'd1);
    check("t6_dout", {24'd0, bus.data_out}, 32'h5A);
`endif
    bus.rx_error = 1'b0;

    // Reset with seven entries stored
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({1'b0, 8'h60 + 8'(i)});
      wr(8'h60 + 8'(i), 1'b0);
    end
    check("rst7_count_before", {27'd0, bus.count}, 32'd7);
    bus.rd_en = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rd_en = 1'b0;
    exp_q.delete();
    check("rst7_count", {27'd0, bus.count}, 32'd0);
    check("rst7_empty", {31'd0, bus.empty}, 32'd1);
    check("rst7_valid", {31'd0, bus.data_valid}, 32'd0);
    tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
